// File: rtl/fetch_req_pkg.sv
// Shared widths, reset address and FSM encoding for the instruction-fetch request stage.
package fetch_req_pkg;

    localparam int unsigned BR_BUS_LEN    = 33;
    localparam int unsigned FETCH_BUS_LEN = 64;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

    typedef enum logic [1:0] {
        FsReq  = 2'd0,
        FsWait = 2'd1,
        FsHold = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_pkt_t;

    // Sequential fetch address; wraps modulo 2^32 by design.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry {inst, pc} holding register used when IF cannot take a returned fetch.
module fetch_buf (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    logic [31:0] inst_q;
    logic [31:0] pc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            inst_q <= '0;
            pc_q   <= '0;
        end else if (load_i) begin
            inst_q <= inst_i;
            pc_q   <= pc_i;
        end
    end

    assign inst_o = inst_q;
    assign pc_o   = pc_q;

endmodule

// File: rtl/fetch_req.sv
// Fetch request stage: owns the PC, drives the instruction SRAM bus with one outstanding
// transaction, absorbs redirects and hands {inst, pc} to IF under valid/allow_in.
module fetch_req
    import fetch_req_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,

    output logic                     inst_sram_req,
    output logic                     inst_sram_wr,
    output logic [1:0]               inst_sram_size,
    output logic [3:0]               inst_sram_wstrb,
    output logic [31:0]              inst_sram_addr,
    output logic [31:0]              inst_sram_wdata,
    input  logic                     inst_sram_addr_ok,
    input  logic                     inst_sram_data_ok,
    input  logic [31:0]              inst_sram_rdata,

    input  logic [BR_BUS_LEN-1:0]    BR_BUS,
    input  logic                     excp_flush,
    input  logic [31:0]              excp_target,

    input  logic                     IF_allow_in,
    output logic                     fetch_valid,
    output logic [FETCH_BUS_LEN-1:0] fetch_bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  cur_pc_q, cur_pc_d;
    logic         cancel_q, cancel_d;

    logic         br_taken;
    logic [31:0]  br_target;
    logic         redirect;
    logic [31:0]  redir_pc;

    logic         buf_load;
    logic         buf_clear;
    logic [31:0]  buf_inst;
    logic [31:0]  buf_pc;
    fetch_pkt_t   out_pkt;

    assign br_taken  = BR_BUS[0];
    assign br_target = BR_BUS[32:1];
    assign redirect  = excp_flush | br_taken;
    // Exception/ertn redirects are older than any branch in ID, so they win.
    assign redir_pc  = excp_flush ? excp_target : br_target;

    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = 32'h0;
    assign inst_sram_addr  = pc_q;

    fetch_buf u_fetch_buf (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .inst_i  (inst_sram_rdata),
        .pc_i    (cur_pc_q),
        .inst_o  (buf_inst),
        .pc_o    (buf_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FsReq;
            pc_q     <= RESET_PC;
            cur_pc_q <= '0;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cur_pc_q <= cur_pc_d;
            cancel_q <= cancel_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cur_pc_d  = cur_pc_q;
        cancel_d  = cancel_q;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        unique case (state_q)
            FsReq: begin
                if (inst_sram_addr_ok) begin
                    state_d  = FsWait;
                    cur_pc_d = pc_q;
                    pc_d     = redirect ? redir_pc : next_pc(pc_q);
                    // Request already accepted: its data must be thrown away on return.
                    cancel_d = redirect;
                end else if (redirect) begin
                    pc_d = redir_pc;
                end
            end
            FsWait: begin
                if (inst_sram_data_ok) begin
                    state_d  = FsReq;
                    cancel_d = 1'b0;
                    if (redirect) begin
                        pc_d = redir_pc;
                    end else if (!cancel_q && !IF_allow_in) begin
                        state_d  = FsHold;
                        buf_load = 1'b1;
                    end
                end else if (redirect) begin
                    cancel_d = 1'b1;
                    pc_d     = redir_pc;
                end
            end
            FsHold: begin
                if (redirect) begin
                    state_d   = FsReq;
                    pc_d      = redir_pc;
                    buf_clear = 1'b1;
                end else if (IF_allow_in) begin
                    state_d   = FsReq;
                    buf_clear = 1'b1;
                end
            end
            default: begin
                state_d = FsReq;
            end
        endcase
    end

    always_comb begin
        inst_sram_req = 1'b0;
        fetch_valid   = 1'b0;
        out_pkt.inst  = buf_inst;
        out_pkt.pc    = buf_pc;
        if (!reset) begin
            unique case (state_q)
                FsReq: begin
                    inst_sram_req = 1'b1;
                end
                FsWait: begin
                    out_pkt.inst = inst_sram_rdata;
                    out_pkt.pc   = cur_pc_q;
                    fetch_valid  = inst_sram_data_ok & ~cancel_q & ~redirect;
                end
                FsHold: begin
                    fetch_valid = ~redirect;
                end
                default: begin
                    inst_sram_req = 1'b0;
                end
            endcase
        end
    end

    assign fetch_bus = out_pkt;

endmodule

// File: tb/tb_fetch_req.sv
// Bench for fetch_req: directed scenarios plus randomized traffic against a transaction model.
module tb_fetch_req;
    import fetch_req_pkg::*;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     inst_sram_req, inst_sram_wr;
    logic [1:0]               inst_sram_size;
    logic [3:0]               inst_sram_wstrb;
    logic [31:0]              inst_sram_addr, inst_sram_wdata;
    logic                     inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0]              inst_sram_rdata;
    logic [BR_BUS_LEN-1:0]    BR_BUS;
    logic                     excp_flush;
    logic [31:0]              excp_target;
    logic                     IF_allow_in;
    logic                     fetch_valid;
    logic [FETCH_BUS_LEN-1:0] fetch_bus;

    always #5 clk = ~clk;

    fetch_req #(.RESET_PC(RST_PC)) dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .BR_BUS            (BR_BUS),
        .excp_flush        (excp_flush),
        .excp_target       (excp_target),
        .IF_allow_in       (IF_allow_in),
        .fetch_valid       (fetch_valid),
        .fetch_bus         (fetch_bus)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus knobs for the coming cycle.
    logic        s_rst, s_br, s_ex, s_allow, s_aok;
    logic [31:0] s_br_tgt, s_ex_tgt;
    int          s_lat;

    // Memory slave: one pending read with a countdown to data_ok.
    bit          sl_pend = 0;
    logic [31:0] sl_addr = '0;
    int          sl_lat  = 0;
    logic [31:0] cap_addr;

    // Transaction model: next fetch pc, the outstanding read, and a held result.
    bit          m_out = 0, m_killed = 0, m_held = 0;
    logic [31:0] m_pc = RST_PC, m_out_pc = '0, m_held_pc = '0;

    logic        e_req, e_valid;
    logic [31:0] e_addr;
    logic [63:0] e_bus;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1e80_0000;
    endfunction

    task automatic set_stim(input logic rst, input logic br, input logic [31:0] brt,
                            input logic ex, input logic [31:0] ext, input logic allow,
                            input logic aok, input int lat);
        s_rst = rst; s_br = br; s_br_tgt = brt; s_ex = ex; s_ex_tgt = ext;
        s_allow = allow; s_aok = aok; s_lat = lat;
    endtask

    // Drive this cycle's inputs, derive expectations, then wait for the sampling edge.
    task automatic settle();
        logic [31:0] p;
        reset             = s_rst;
        BR_BUS            = {s_br_tgt, s_br};
        excp_flush        = s_ex;
        excp_target       = s_ex_tgt;
        IF_allow_in       = s_allow;
        inst_sram_data_ok = sl_pend && (sl_lat == 0);
        inst_sram_rdata   = inst_sram_data_ok ? mem_word(sl_addr) : 32'hdead_beef;
        #1;
        inst_sram_addr_ok = inst_sram_req && s_aok;
        e_req   = !s_rst && !m_out && !m_held;
        e_addr  = m_pc;
        e_valid = !s_rst && !(s_br || s_ex) &&
                  (m_held || (m_out && !m_killed && inst_sram_data_ok));
        p       = m_held ? m_held_pc : m_out_pc;
        e_bus   = {mem_word(p), p};
        @(negedge clk);
        cap_addr = inst_sram_addr;
    endtask

    task automatic advance();
        logic        redir;
        logic [31:0] tgt;
        @(posedge clk);
        redir = s_br || s_ex;
        tgt   = s_ex ? s_ex_tgt : s_br_tgt;
        if (inst_sram_data_ok) sl_pend = 0;
        else if (sl_pend && sl_lat > 0) sl_lat--;
        if (inst_sram_addr_ok) begin
            sl_pend = 1; sl_addr = cap_addr; sl_lat = s_lat;
        end
        if (s_rst) begin
            m_pc = RST_PC; m_out = 0; m_held = 0; m_killed = 0;
        end else if (m_held) begin
            if (redir || s_allow) m_held = 0;
            if (redir) m_pc = tgt;
        end else if (m_out) begin
            if (inst_sram_data_ok) begin
                m_out = 0;
                if (!m_killed && !redir && !s_allow) begin
                    m_held = 1; m_held_pc = m_out_pc;
                end
            end
            if (redir) begin
                if (m_out) m_killed = 1;
                m_pc = tgt;
            end
        end else if (inst_sram_addr_ok) begin
            m_out = 1; m_out_pc = m_pc; m_killed = redir;
            m_pc = redir ? tgt : m_pc + 32'd4;
        end else if (redir) begin
            m_pc = tgt;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            set_stim(1, 0, 0, 0, 0, 1, 0, 0);
            settle();
            checks++;
            if (inst_sram_req !== 1'b0) begin
                errors++; $display("FAIL reset_req got %b want 0", inst_sram_req);
            end
            checks++;
            if (fetch_valid !== 1'b0) begin
                errors++; $display("FAIL reset_valid got %b want 0", fetch_valid);
            end
            advance();
        end
    endtask

    task automatic test_basic();
        set_stim(0, 0, 0, 0, 0, 1, 1, 0);
        settle();
        checks++;
        if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_0000) begin
            errors++;
            $display("FAIL basic_req0 got req %b addr %h want 1 1c000000",
                     inst_sram_req, inst_sram_addr);
        end
        advance();
        set_stim(0, 0, 0, 0, 0, 1, 0, 0);
        settle();
        checks++;
        if (fetch_valid !== 1'b1 || fetch_bus !== 64'h0280_0000_1c00_0000) begin
            errors++;
            $display("FAIL basic_deliver got v %b bus %h want 1 028000001c000000",
                     fetch_valid, fetch_bus);
        end
        checks++;
        if (inst_sram_req !== 1'b0) begin
            errors++; $display("FAIL basic_wait_req got %b want 0", inst_sram_req);
        end
        advance();
        settle();
        checks++;
        if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_0004) begin
            errors++;
            $display("FAIL basic_req1 got req %b addr %h want 1 1c000004",
                     inst_sram_req, inst_sram_addr);
        end
        advance();
    endtask

    task automatic test_hold();
        logic [63:0] want;
        want = {mem_word(32'h1c00_0004), 32'h1c00_0004};
        set_stim(0, 0, 0, 0, 0, 0, 1, 0);
        settle();
        advance();
        set_stim(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (fetch_valid !== 1'b1 || fetch_bus !== want) begin
                errors++;
                $display("FAIL hold_stable cyc %0d got v %b bus %h want 1 %h",
                         i, fetch_valid, fetch_bus, want);
            end
            checks++;
            if (inst_sram_req !== 1'b0) begin
                errors++; $display("FAIL hold_no_req cyc %0d got %b want 0", i, inst_sram_req);
            end
            advance();
        end
        set_stim(0, 0, 0, 0, 0, 1, 0, 0);
        settle();
        checks++;
        if (fetch_valid !== 1'b1 || inst_sram_req !== 1'b0) begin
            errors++;
            $display("FAIL hold_release got v %b req %b want 1 0", fetch_valid, inst_sram_req);
        end
        advance();
        settle();
        checks++;
        if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_0008) begin
            errors++;
            $display("FAIL hold_next_req got req %b addr %h want 1 1c000008",
                     inst_sram_req, inst_sram_addr);
        end
        advance();
    endtask

    task automatic test_branch_wait();
        set_stim(0, 0, 0, 0, 0, 1, 1, 2);
        settle();
        advance();
        set_stim(0, 1, 32'h1c00_0100, 0, 0, 1, 0, 0);
        settle();
        advance();
        set_stim(0, 0, 0, 0, 0, 1, 0, 0);
        settle();
        advance();
        settle();
        checks++;
        if (inst_sram_data_ok !== 1'b1 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL br_wait_drop got data_ok %b v %b want 1 0",
                     inst_sram_data_ok, fetch_valid);
        end
        advance();
        settle();
        checks++;
        if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_0100) begin
            errors++;
            $display("FAIL br_wait_target got req %b addr %h want 1 1c000100",
                     inst_sram_req, inst_sram_addr);
        end
        advance();
    endtask

    task automatic test_dual_redirect();
        set_stim(0, 1, 32'h1c00_0100, 1, 32'h1c00_8000, 1, 1, 1);
        settle();
        checks++;
        if (inst_sram_req !== 1'b1 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL dual_req got req %b v %b want 1 0", inst_sram_req, fetch_valid);
        end
        advance();
        set_stim(0, 0, 0, 0, 0, 1, 0, 0);
        settle();
        advance();
        settle();
        checks++;
        if (inst_sram_data_ok !== 1'b1 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL dual_cancel got data_ok %b v %b want 1 0",
                     inst_sram_data_ok, fetch_valid);
        end
        advance();
        settle();
        checks++;
        if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_8000) begin
            errors++;
            $display("FAIL dual_target got req %b addr %h want 1 1c008000",
                     inst_sram_req, inst_sram_addr);
        end
        advance();
    endtask

    task automatic test_addr_stall();
        logic [31:0] want;
        for (int i = 0; i < 4; i++) begin
            set_stim(0, (i == 1), 32'h1c00_0200, 0, 0, 1, 0, 0);
            settle();
            want = (i < 2) ? 32'h1c00_8000 : 32'h1c00_0200;
            checks++;
            if (inst_sram_req !== 1'b1 || inst_sram_addr !== want) begin
                errors++;
                $display("FAIL stall_addr cyc %0d got req %b addr %h want 1 %h",
                         i, inst_sram_req, inst_sram_addr, want);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        set_stim(0, 0, 0, 0, 0, 1, 1, 2);
        settle();
        advance();
        set_stim(1, 0, 0, 0, 0, 1, 0, 0);
        settle();
        checks++;
        if (inst_sram_req !== 1'b0 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_in_reset got req %b v %b want 0 0", inst_sram_req, fetch_valid);
        end
        advance();
        set_stim(0, 0, 0, 0, 0, 1, 0, 0);
        settle();
        checks++;
        if (inst_sram_req !== 1'b1 || inst_sram_addr !== RST_PC) begin
            errors++;
            $display("FAIL rstmid_req got req %b addr %h want 1 %h",
                     inst_sram_req, inst_sram_addr, RST_PC);
        end
        advance();
        settle();
        checks++;
        if (inst_sram_data_ok !== 1'b1 || fetch_valid !== 1'b0 || inst_sram_req !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_stale got data_ok %b v %b req %b want 1 0 1",
                     inst_sram_data_ok, fetch_valid, inst_sram_req);
        end
        advance();
        set_stim(0, 0, 0, 0, 0, 1, 1, 0);
        settle();
        advance();
        set_stim(0, 0, 0, 0, 0, 1, 0, 0);
        settle();
        checks++;
        if (fetch_valid !== 1'b1 || fetch_bus !== 64'h0280_0000_1c00_0000) begin
            errors++;
            $display("FAIL rstmid_first got v %b bus %h want 1 028000001c000000",
                     fetch_valid, fetch_bus);
        end
        advance();
        settle();
        advance();
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        int          r;
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 7);
            tgt = (r == 0) ? 32'hffff_fffc : (r == 1) ? 32'hffff_fff8 : ($urandom & 32'hffff_fffc);
            set_stim(0, ($urandom_range(0, 9) == 0), tgt, ($urandom_range(0, 24) == 0),
                     $urandom & 32'hffff_fffc, ($urandom_range(0, 3) != 0),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 3));
            settle();
            checks++;
            if (inst_sram_req !== e_req) begin
                errors++; $display("FAIL rand_req cyc %0d got %b want %b", c, inst_sram_req, e_req);
            end
            if (e_req) begin
                checks++;
                if (inst_sram_addr !== e_addr) begin
                    errors++;
                    $display("FAIL rand_addr cyc %0d got %h want %h", c, inst_sram_addr, e_addr);
                end
            end
            checks++;
            if (fetch_valid !== e_valid) begin
                errors++;
                $display("FAIL rand_valid cyc %0d got %b want %b", c, fetch_valid, e_valid);
            end
            if (e_valid) begin
                checks++;
                if (fetch_bus !== e_bus) begin
                    errors++;
                    $display("FAIL rand_bus cyc %0d got %h want %h", c, fetch_bus, e_bus);
                end
            end
            advance();
        end
    endtask

    initial begin
        reset = 1'b1; BR_BUS = '0; excp_flush = 1'b0; excp_target = '0; IF_allow_in = 1'b0;
        inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;
        test_reset();
        test_basic();
        test_hold();
        test_branch_wait();
        test_dual_redirect();
        test_addr_stall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
